reg_bank_p4_feeder: RTL and testbench

- Instruction queue placed directly upstream of the 4-register P4 register bank.
- Accepts 12-bit instructions (4-bit opcode, 8-bit immediate) from a producer over a valid/ready handshake and buffers them in a FIFO.
- Issues at most one instruction per cycle onto the bank's inst/inst_en pair, gated by issue_en.
- Treats instructions as opaque: no opcode decode, so bad or NOP opcodes pass through unchanged. The bank handles them.

---
 rtl/reg_bank_p4_feeder.sv | 116 +++++++++++
 tb/tb_reg_bank_p4_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_p4_feeder.sv
// reg_bank_p4_feeder: instruction FIFO feeding the 4-register P4 register bank.
// Buffers opaque instructions from a valid/ready producer and issues at most one
// per cycle onto inst/inst_en when issue_en allows. Nothing is decoded.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset, highest priority
//   in_inst   in   instruction from producer ({opcode[11:8], imm[7:0]})
//   in_valid  in   in_inst valid this cycle
//   in_ready  out  combinational; FIFO can accept this cycle
//   issue_en  in   downstream permits an issue this cycle
//   flush     in   discard all queued entries (issued is kept)
//   inst      out  registered instruction to the bank, holds between issues
//   inst_en   out  registered one-cycle strobe per issued instruction
//   count     out  registered FIFO occupancy, 0..2**DEPTH_LOG2
//   issued    out  registered 8-bit count of issued instructions, wraps
module reg_bank_p4_feeder #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned INST_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  issue_en,
    input  logic                  flush,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_en,
    output logic [DEPTH_LOG2:0]   count,
    output logic [7:0]            issued
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned IW    = 8;

    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  inst_en_q, inst_en_d;
    logic [IW-1:0]         issued_q, issued_d;
    logic                  push, pop;

    // Ready ignores a same-cycle pop: no pass-through when full.
    always_comb begin
        in_ready = !reset && !flush && (count_q != CW'(DEPTH));
        push     = in_valid && in_ready;
        pop      = issue_en && (count_q != '0) && !flush && !reset;
    end

    // Next-state for pointers, occupancy and the issue register.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        inst_d    = inst_q;
        inst_en_d = 1'b0;
        issued_d  = issued_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                inst_d    = mem_q[rd_ptr_q];
                inst_en_d = 1'b1;
                issued_d  = issued_q + IW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            inst_q    <= '0;
            inst_en_q <= 1'b0;
            issued_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            inst_q    <= inst_d;
            inst_en_q <= inst_en_d;
            issued_q  <= issued_d;
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_inst;
        end
    end

    assign inst    = inst_q;
    assign inst_en = inst_en_q;
    assign count   = count_q;
    assign issued  = issued_q;

endmodule

// File: tb/tb_reg_bank_p4_feeder.sv
// Testbench for reg_bank_p4_feeder: directed scenarios with random payloads,
// checked every cycle against a queue-based reference model.
module tb_reg_bank_p4_feeder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] in_inst;
    logic        in_valid;
    logic        in_ready;
    logic        issue_en;
    logic        flush;
    logic [11:0] inst;
    logic        inst_en;
    logic [2:0]  count;
    logic [7:0]  issued;

    always #5 clock = ~clock;

    reg_bank_p4_feeder #(.DEPTH_LOG2(2), .INST_WIDTH(12)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_inst  (in_inst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .issue_en (issue_en),
        .flush    (flush),
        .inst     (inst),
        .inst_en  (inst_en),
        .count    (count),
        .issued   (issued)
    );

    int checks = 0;
    int errors = 0;

    // Producer backlog and reference model state.
    logic [11:0] pq[$];
    logic [11:0] mq[$];
    logic [11:0] m_inst;
    logic        m_en;
    logic [7:0]  m_issued;
    bit          offer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive producer, check ready, advance model, check outputs.
    task automatic cycle();
        logic m_ready, m_push, m_pop;
        in_valid = (pq.size() > 0) && offer;
        in_inst  = (pq.size() > 0) ? pq[0] : 12'($urandom);
        #1;
        m_ready = !reset && !flush && (mq.size() < 4);
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        m_push = in_valid && m_ready;
        m_pop  = issue_en && (mq.size() != 0) && !flush && !reset;
        @(posedge clock);
        if (reset) begin
            mq.delete();
            m_inst   = '0;
            m_en     = 1'b0;
            m_issued = '0;
        end else if (flush) begin
            mq.delete();
            m_en = 1'b0;
        end else begin
            m_en = m_pop;
            if (m_pop) begin
                m_inst   = mq.pop_front();
                m_issued = m_issued + 8'd1;
            end
            if (m_push) mq.push_back(in_inst);
        end
        if (m_push) void'(pq.pop_front());
        #1;
        chk("inst_en", 32'(inst_en), 32'(m_en));
        chk("inst",    32'(inst),    32'(m_inst));
        chk("count",   32'(count),   32'(mq.size()));
        chk("issued",  32'(issued),  32'(m_issued));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Bounded drain: stop once producer and model are both empty.
    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((pq.size() > 0 || mq.size() > 0) && k < limit) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 32'(k < limit), 32'(1));
    endtask

    initial begin
        offer    = 1'b1;
        reset    = 1'b1;
        flush    = 1'b0;
        issue_en = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        m_inst   = '0;
        m_en     = 1'b0;
        m_issued = '0;
        run(2);
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_inst_en", 32'(inst_en), 32'(0));
        reset = 1'b0;

        // Back-to-back pushes with issue enabled.
        issue_en = 1'b1;
        pq.push_back(12'h1BA); pq.push_back(12'h2FE);
        pq.push_back(12'h323); pq.push_back(12'h443);
        run(7);
        chk("t1_issued", 32'(issued), 32'(4));

        // Fill with issue held, fifth waits on the producer side.
        issue_en = 1'b0;
        for (int i = 0; i < 5; i++) pq.push_back(12'($urandom));
        run(6);
        chk("t2_full_count", 32'(count), 32'(4));
        chk("t2_backlog", 32'(pq.size()), 32'(1));
        issue_en = 1'b1;
        drain(20);

        // Fill, drop to 3, then continuous push+pop through pointer wrap.
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) pq.push_back(12'($urandom));
        run(5);
        issue_en = 1'b1;
        for (int i = 0; i < 10; i++) pq.push_back(12'($urandom));
        run(4);
        chk("t3_steady_count", 32'(count), 32'(3));
        drain(40);

        // Opaque opcodes pass unchanged.
        pq.push_back(12'hFAB);
        pq.push_back({4'h0, 8'($urandom)});
        drain(10);

        // Flush with a simultaneous offer that must be refused.
        issue_en = 1'b0;
        for (int i = 0; i < 3; i++) pq.push_back(12'($urandom));
        run(4);
        pq.push_back(12'h127);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        chk("t5_refused", 32'(pq.size()), 32'(1));
        pq.delete();
        issue_en = 1'b1;
        run(2);

        // Random traffic with random issue gating and producer gaps.
        for (int i = 0; i < 300; i++) begin
            if (pq.size() < 3) pq.push_back(12'($urandom));
            issue_en = 1'($urandom_range(0, 3) != 0);
            offer    = 1'($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 40) == 0);
            cycle();
        end
        flush    = 1'b0;
        offer    = 1'b1;
        issue_en = 1'b1;
        pq.delete();
        drain(10);

        // Exactly 256 issues from reset wraps issued to zero.
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) pq.push_back(12'($urandom));
        drain(400);
        chk("t6_wrap", 32'(issued), 32'(0));

        // Reset mid-queue, then a single post-reset push.
        issue_en = 1'b0;
        pq.push_back(12'($urandom)); pq.push_back(12'($urandom));
        run(3);
        chk("t6_pre_rst_count", 32'(count), 32'(2));
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        chk("t6_rst_count", 32'(count), 32'(0));
        issue_en = 1'b1;
        pq.push_back(12'h11A);
        run(3);
        chk("t6_post_issued", 32'(issued), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
